// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES round controller.
// Holds the FSM state encoding, the inner step indices and the default round count.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRound,
        StFinal,
        StDone
    } ctrl_state_e;

    localparam int unsigned DEFAULT_NUM_ROUNDS = 10;

    localparam logic [3:0] STEP_SUB   = 4'd0;
    localparam logic [3:0] STEP_SHIFT = 4'd1;
    localparam logic [3:0] STEP_MIX   = 4'd2;
    localparam logic [3:0] STEP_ARK   = 4'd3;

    function automatic logic is_busy(input ctrl_state_e state);
        return (state == StLoad) || (state == StRound) || (state == StFinal);
    endfunction

endpackage

// File: rtl/aes_inner_state_counter.sv
// Datapath inner-state counter: counts steps within a round.
// Synchronously cleared whenever the controller asserts its clear request.
module aes_inner_state_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    output logic [3:0] count
);

    logic [3:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 4'd0;
        end else if (clr) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_q + 4'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/aes_round_step_decode.sv
// Combinational decode of controller state and inner step into datapath enables.
// Any out-of-range step forces a counter clear so the datapath resynchronises.
module aes_round_step_decode
    import aes_ctrl_pkg::*;
(
    input  ctrl_state_e state,
    input  logic [3:0]  step,
    output logic        load_en,
    output logic        sub_en,
    output logic        shift_en,
    output logic        mix_en,
    output logic        ark_en,
    output logic        key_exp_en,
    output logic        rst_synch
);

    always_comb begin
        load_en    = 1'b0;
        sub_en     = 1'b0;
        shift_en   = 1'b0;
        mix_en     = 1'b0;
        ark_en     = 1'b0;
        key_exp_en = 1'b0;
        rst_synch  = 1'b1;
        unique case (state)
            StLoad: begin
                load_en = 1'b1;
                ark_en  = 1'b1;
            end
            StRound, StFinal: begin
                rst_synch = 1'b0;
                case (step)
                    STEP_SUB: begin
                        sub_en     = 1'b1;
                        key_exp_en = 1'b1;
                    end
                    STEP_SHIFT: shift_en = 1'b1;
                    // The final round skips MixColumns, leaving an idle step.
                    STEP_MIX:   mix_en = (state == StRound);
                    STEP_ARK: begin
                        ark_en    = 1'b1;
                        rst_synch = 1'b1;
                    end
                    default:    rst_synch = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/aes_datapath_round_controller.sv
// AES block round controller: sequences load, round steps and the final round.
// State, round index and done are registered; enables are decoded from state and step.
module aes_datapath_round_controller
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS      = DEFAULT_NUM_ROUNDS,
    parameter int unsigned STEPS_PER_ROUND = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] inner_state_counter,
    output logic       rst_synch,
    output logic       ready,
    output logic       busy,
    output logic [3:0] round_num,
    output logic       load_en,
    output logic       sub_en,
    output logic       shift_en,
    output logic       mix_en,
    output logic       ark_en,
    output logic       key_exp_en,
    output logic       done
);

    localparam logic [3:0] LAST_STEP  = 4'(STEPS_PER_ROUND - 1);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    ctrl_state_e state_q, state_d;
    logic [3:0]  round_q, round_d;
    logic        done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            round_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                round_d = 4'd1;
                state_d = (LAST_ROUND == 4'd1) ? StFinal : StRound;
            end
            StRound: begin
                if (inner_state_counter == LAST_STEP) begin
                    round_d = round_q + 4'd1;
                    if (round_q + 4'd1 == LAST_ROUND) begin
                        state_d = StFinal;
                    end
                end
            end
            StFinal: begin
                if (inner_state_counter == LAST_STEP) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                round_d = 4'd0;
            end
            default: begin
                state_d = StIdle;
                round_d = 4'd0;
            end
        endcase
        done_d = (state_d == StDone);
    end

    always_comb begin
        ready     = (state_q == StIdle);
        busy      = is_busy(state_q);
        round_num = round_q;
        done      = done_q;
    end

    aes_round_step_decode u_step_decode (
        .state      (state_q),
        .step       (inner_state_counter),
        .load_en    (load_en),
        .sub_en     (sub_en),
        .shift_en   (shift_en),
        .mix_en     (mix_en),
        .ark_en     (ark_en),
        .key_exp_en (key_exp_en),
        .rst_synch  (rst_synch)
    );

endmodule

// File: tb/tb_aes_datapath_round_controller.sv
// Self-checking bench for the AES round controller with the real inner-state counter.
// Expected outputs come from a cycle-offset timeline model of one block.
module tb_aes_datapath_round_controller;

    localparam int NR  = 10;
    localparam int SPR = 4;

    typedef struct packed {
        logic       load;
        logic       sub;
        logic       shift;
        logic       mix;
        logic       ark;
        logic       kexp;
        logic       rsync;
        logic       ready;
        logic       busy;
        logic       done;
        logic [3:0] round;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] inner_state_counter;
    logic [3:0] cnt;
    logic       force_en;
    logic [3:0] force_val;
    logic       rst_synch;
    logic       ready;
    logic       busy;
    logic [3:0] round_num;
    logic       load_en;
    logic       sub_en;
    logic       shift_en;
    logic       mix_en;
    logic       ark_en;
    logic       key_exp_en;
    logic       done;

    int checks = 0;
    int errors = 0;

    aes_inner_state_counter u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (rst_synch),
        .count (cnt)
    );

    assign inner_state_counter = force_en ? force_val : cnt;

    aes_datapath_round_controller #(
        .NUM_ROUNDS      (NR),
        .STEPS_PER_ROUND (SPR)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .inner_state_counter (inner_state_counter),
        .rst_synch           (rst_synch),
        .ready               (ready),
        .busy                (busy),
        .round_num           (round_num),
        .load_en             (load_en),
        .sub_en              (sub_en),
        .shift_en            (shift_en),
        .mix_en              (mix_en),
        .ark_en              (ark_en),
        .key_exp_en          (key_exp_en),
        .done                (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs k cycles after start was accepted (k=0 means idle).
    function automatic obs_t model(input int k);
        obs_t e;
        int   r;
        int   s;
        e = '0;
        if (k == 0) begin
            e.ready = 1'b1;
            e.rsync = 1'b1;
        end else if (k == 1) begin
            e.load  = 1'b1;
            e.ark   = 1'b1;
            e.rsync = 1'b1;
            e.busy  = 1'b1;
        end else if (k <= 1 + NR * SPR) begin
            r       = (k - 2) / SPR + 1;
            s       = (k - 2) % SPR;
            e.busy  = 1'b1;
            e.round = 4'(r);
            e.sub   = (s == 0);
            e.kexp  = (s == 0);
            e.shift = (s == 1);
            e.mix   = (s == 2) && (r < NR);
            e.ark   = (s == 3);
            e.rsync = (s == 3);
        end else begin
            e.done  = 1'b1;
            e.rsync = 1'b1;
            e.round = 4'(NR);
        end
        return e;
    endfunction

    function automatic obs_t cur_obs();
        return {load_en, sub_en, shift_en, mix_en, ark_en, key_exp_en, rst_synch,
                ready, busy, done, round_num};
    endfunction

    // Advance one cycle, then check the per-cycle invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        if ($countones({sub_en, shift_en, mix_en}) > 1 || (!done && (ready == busy)) ||
            round_num > 4'(NR)) begin
            errors++;
            $display("FAIL invariants t=%0t sub/shift/mix=%b%b%b ready=%b busy=%b round=%0d",
                     $time, sub_en, shift_en, mix_en, ready, busy, round_num);
        end
    endtask

    // One block from IDLE through DONE and back to IDLE, checked against the model.
    task automatic run_block(input int gap, input bit hold, input bit noise, input string tag);
        obs_t o;
        int   n_sub = 0;
        int   n_shift = 0;
        int   n_mix = 0;
        int   n_ark = 0;
        for (int i = 0; i < gap; i++) begin
            o = cur_obs();
            checks++;
            if (o !== model(0)) begin
                errors++;
                $display("FAIL %s idle got %b want %b", tag, o, model(0));
            end
            tick();
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_start got %b want 1", tag, ready);
        end
        start = 1'b1;
        for (int k = 1; k <= 2 + NR * SPR; k++) begin
            tick();
            start = hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
            o = cur_obs();
            n_sub   += int'(sub_en);
            n_shift += int'(shift_en);
            n_mix   += int'(mix_en);
            n_ark   += int'(ark_en);
            checks++;
            if (o !== model(k)) begin
                errors++;
                $display("FAIL %s k=%0d got %b want %b", tag, k, o, model(k));
            end
        end
        tick();
        start = hold;
        o = cur_obs();
        checks++;
        if (o !== model(0)) begin
            errors++;
            $display("FAIL %s back_to_idle got %b want %b", tag, o, model(0));
        end
        checks++;
        if (n_sub !== NR || n_shift !== NR || n_mix !== NR - 1 || n_ark !== NR + 1) begin
            errors++;
            $display("FAIL %s enable_counts got sub=%0d shift=%0d mix=%0d ark=%0d want %0d %0d %0d %0d",
                     tag, n_sub, n_shift, n_mix, n_ark, NR, NR, NR - 1, NR + 1);
        end
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        o = cur_obs();
        checks++;
        if (o !== model(0)) begin
            errors++;
            $display("FAIL reset_state got %b want %b", o, model(0));
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        o = cur_obs();
        checks++;
        if (o !== model(0)) begin
            errors++;
            $display("FAIL reset_release got %b want %b", o, model(0));
        end
    endtask

    task automatic test_latency();
        start = 1'b1;
        for (int k = 1; k <= 43; k++) begin
            tick();
            start = 1'b0;
            if (k == 1) begin
                checks++;
                if (load_en !== 1'b1) begin
                    errors++;
                    $display("FAIL latency_load got %b want 1", load_en);
                end
            end
            if (k == 2) begin
                checks++;
                if (round_num !== 4'd1) begin
                    errors++;
                    $display("FAIL latency_round1 got %0d want 1", round_num);
                end
            end
            checks++;
            if (done !== (k == 42)) begin
                errors++;
                $display("FAIL latency_done k=%0d got %b want %b", k, done, k == 42);
            end
            if (k == 43) begin
                checks++;
                if (ready !== 1'b1) begin
                    errors++;
                    $display("FAIL latency_ready got %b want 1", ready);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        run_block(0, 1'b1, 1'b0, "b2b_first");
        run_block(0, 1'b1, 1'b0, "b2b_second");
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        obs_t o;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            start = 1'b0;
            o = cur_obs();
            checks++;
            if (o !== model(k)) begin
                errors++;
                $display("FAIL midrst_pre k=%0d got %b want %b", k, o, model(k));
            end
        end
        rst = 1'b1;
        #1;
        o = cur_obs();
        checks++;
        if (o !== model(0)) begin
            errors++;
            $display("FAIL midrst_same_cycle got %b want %b", o, model(0));
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick();
            o = cur_obs();
            checks++;
            if (o !== model(0)) begin
                errors++;
                $display("FAIL midrst_no_done i=%0d got %b want %b", i, o, model(0));
            end
        end
        run_block(0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_resync();
        obs_t o;
        obs_t e;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            start = 1'b0;
            o = cur_obs();
            checks++;
            if (o !== model(k)) begin
                errors++;
                $display("FAIL resync_pre k=%0d got %b want %b", k, o, model(k));
            end
        end
        force_val = 4'd9;
        force_en  = 1'b1;
        e = '0;
        e.rsync = 1'b1;
        e.busy  = 1'b1;
        e.round = 4'd3;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                #1;
            end else begin
                tick();
            end
            o = cur_obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL resync_hold i=%0d got %b want %b", i, o, e);
            end
        end
        force_en = 1'b0;
        #1;
        for (int k = 10; k <= 43; k++) begin
            if (k > 10) begin
                tick();
            end
            o = cur_obs();
            checks++;
            if (o !== model(k == 43 ? 0 : k)) begin
                errors++;
                $display("FAIL resync_resume k=%0d got %b want %b", k, o, model(k == 43 ? 0 : k));
            end
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 4; b++) begin
            run_block(int'($urandom_range(0, 5)), 1'b0, 1'b1, "random");
        end
    endtask

    initial begin
        start     = 1'b0;
        force_en  = 1'b0;
        force_val = 4'd0;
        test_reset();
        test_latency();
        run_block(2, 1'b0, 1'b0, "full_run");
        test_back_to_back();
        test_reset_mid();
        test_resync();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
